// File: rtl/nx_axbs_pkg.sv
// Shared types and sizing helpers for the iterative digit-serial multiplier.
package nx_axbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // B is widened by one bit so an unsigned operand still has a zero sign digit.
  function automatic int unsigned num_digits(input int unsigned size_b, input int unsigned digit);
    return (size_b + digit) / digit;
  endfunction

  function automatic int unsigned acc_width(input int unsigned size_a, input int unsigned size_b,
                                            input int unsigned digit);
    return size_a + 1 + num_digits(size_b, digit) * digit;
  endfunction

endpackage

// File: rtl/nx_axbs_digit.sv
// Combinational (SIZE_A+1) x DIGIT partial product; the digit is signed only when it is B's top digit.
module nx_axbs_digit
  import nx_axbs_pkg::*;
#(
  parameter int unsigned SIZE_A = 32,
  parameter int unsigned DIGIT  = 8
) (
  input  logic [SIZE_A:0]       a_x,
  input  logic [DIGIT-1:0]      digit,
  input  logic                  digit_signed,
  output logic [SIZE_A+DIGIT:0] pp
);

  localparam int unsigned PW = SIZE_A + DIGIT + 1;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] d_ext;

  // Both factors are extended to the result width, so the low PW bits of an
  // unsigned multiply are the exact two's-complement product.
  always_comb begin
    a_ext = {{DIGIT{a_x[SIZE_A]}}, a_x};
    d_ext = {{(SIZE_A + 1){digit_signed & digit[DIGIT-1]}}, digit};
    pp    = a_ext * d_ext;
  end

endmodule

// File: rtl/nx_axbs_iter.sv
// Iterative signed/unsigned multiplier: consumes B MSB-first, DIGIT bits per cycle,
// with ready/valid handshakes on operands and product.
module nx_axbs_iter
  import nx_axbs_pkg::*;
#(
  parameter int unsigned SIZE_A = 32,
  parameter int unsigned SIZE_B = 32,
  parameter int unsigned DIGIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE_A-1:0]        din_a,
  input  logic [SIZE_B-1:0]        din_b,
  input  logic                     sign_a,
  input  logic                     sign_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE_A+SIZE_B-1:0] dout
);

  localparam int unsigned NUM_D = num_digits(SIZE_B, DIGIT);
  localparam int unsigned BW    = NUM_D * DIGIT;
  localparam int unsigned AW    = acc_width(SIZE_A, SIZE_B, DIGIT);
  localparam int unsigned PW    = SIZE_A + DIGIT + 1;
  localparam int unsigned OW    = SIZE_A + SIZE_B;
  localparam int unsigned CW    = (NUM_D > 1) ? $clog2(NUM_D) : 1;
  localparam logic [CW-1:0] CntTop = CW'(NUM_D - 1);

  if (SIZE_A < 2) begin : g_bad_size_a
    $fatal(1, "nx_axbs_iter: SIZE_A must be >= 2");
  end
  if (SIZE_B < 2) begin : g_bad_size_b
    $fatal(1, "nx_axbs_iter: SIZE_B must be >= 2");
  end
  if (DIGIT < 2 || DIGIT > SIZE_B + 1) begin : g_bad_digit
    $fatal(1, "nx_axbs_iter: DIGIT must satisfy 2 <= DIGIT <= SIZE_B+1");
  end

  state_t                state_q, state_d;
  logic [SIZE_A:0]       a_q, a_d;
  logic [BW-1:0]         b_q, b_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [AW-1:0]  acc_next;
  logic signed [AW-1:0]  pp_ext;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [OW-1:0]         dout_q, dout_d;
  logic [PW-1:0]         pp;
  logic                  accept;

  // B is shifted left each cycle, so the current digit is always the top slice.
  nx_axbs_digit #(
    .SIZE_A(SIZE_A),
    .DIGIT (DIGIT)
  ) u_digit (
    .a_x         (a_q),
    .digit       (b_q[BW-1 -: DIGIT]),
    .digit_signed(cnt_q == CntTop),
    .pp          (pp)
  );

  always_comb begin
    pp_ext   = AW'($signed(pp));
    acc_next = (acc_q <<< DIGIT) + pp_ext;
  end

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    out_valid = (state_q == DONE);
    dout      = dout_q;
    accept    = in_valid & in_ready;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d     = {sign_a & din_a[SIZE_A-1], din_a};
          b_d     = {{(BW - SIZE_B){sign_b & din_b[SIZE_B-1]}}, din_b};
          acc_d   = '0;
          cnt_d   = CntTop;
          state_d = BUSY;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d = acc_next;
        b_d   = b_q << DIGIT;
        if (cnt_q == '0) begin
          dout_d  = acc_next[OW-1:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_nx_axbs_iter.sv
// Scoreboard bench for nx_axbs_iter: default configuration plus three swept configurations.
module tb_nx_axbs_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, sign_a, sign_b, out_valid, out_ready;
  logic [31:0] din_a, din_b;
  logic [63:0] dout;

  nx_axbs_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din_a    (din_a),
    .din_b    (din_b),
    .sign_a   (sign_a),
    .sign_b   (sign_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout)
  );

  // Swept configurations: (17,9,4) NUM_D=3; (8,3,4) and (12,7,8) both SIZE_B=DIGIT-1, NUM_D=1.
  logic [2:0]  sw_iv, sw_ir, sw_ov, sw_or, sw_sa, sw_sb;
  logic [16:0] d0_a;
  logic [8:0]  d0_b;
  logic [25:0] d0_y;
  logic [7:0]  d1_a;
  logic [2:0]  d1_b;
  logic [10:0] d1_y;
  logic [11:0] d2_a;
  logic [6:0]  d2_b;
  logic [18:0] d2_y;

  nx_axbs_iter #(.SIZE_A(17), .SIZE_B(9), .DIGIT(4)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]), .din_a(d0_a),
    .din_b(d0_b), .sign_a(sw_sa[0]), .sign_b(sw_sb[0]), .out_valid(sw_ov[0]),
    .out_ready(sw_or[0]), .dout(d0_y)
  );
  nx_axbs_iter #(.SIZE_A(8), .SIZE_B(3), .DIGIT(4)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]), .din_a(d1_a),
    .din_b(d1_b), .sign_a(sw_sa[1]), .sign_b(sw_sb[1]), .out_valid(sw_ov[1]),
    .out_ready(sw_or[1]), .dout(d1_y)
  );
  nx_axbs_iter #(.SIZE_A(12), .SIZE_B(7), .DIGIT(8)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]), .din_a(d2_a),
    .din_b(d2_b), .sign_a(sw_sa[2]), .sign_b(sw_sb[2]), .out_valid(sw_ov[2]),
    .out_ready(sw_or[2]), .dout(d2_y)
  );

  int sw_wa[3] = '{17, 8, 12};
  int sw_wb[3] = '{9, 3, 7};
  int sw_nd[3] = '{3, 1, 1};

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];

  // Behavioural reference: interpret operands as integers, multiply, keep SIZE_A+SIZE_B bits.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input bit sa,
                                        input bit sb, input int wa, input int wb);
    longint av, bv, p;
    logic [63:0] r;
    av = longint'(a);
    bv = longint'(b);
    if (sa && a[wa-1]) av = av - (longint'(1) << wa);
    if (sb && b[wb-1]) bv = bv - (longint'(1) << wb);
    p = av * bv;
    r = p;
    if (wa + wb < 64) r = r & ((64'd1 << (wa + wb)) - 64'd1);
    return r;
  endfunction

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 64'hDEAD_BEEF_DEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] c [5];
    c = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Drives one op on the default DUT; expected value enters the scoreboard at acceptance.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input bit sa, input bit sb,
                          input logic [63:0] exp, input bit ordy, input bit toggle,
                          output logic [63:0] res, output int lat);
    int w;
    res = '0;
    lat = 0;
    @(negedge clk);
    din_a = a; din_b = b; sign_a = sa; sign_b = sb; in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp);
    #1 in_valid = 1'b0;
    out_ready = ordy;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (toggle) begin
        sign_a = ~sign_a;
        sign_b = ~sign_b;
      end
    end
    res = dout;
  endtask

  task automatic sw_op(input int d, input logic [31:0] a, input logic [31:0] b, input bit sa,
                       input bit sb, input logic [63:0] exp, output logic [63:0] res,
                       output int lat);
    int w;
    res = '0;
    lat = 0;
    @(negedge clk);
    case (d)
      0: begin d0_a = a[16:0]; d0_b = b[8:0]; end
      1: begin d1_a = a[7:0]; d1_b = b[2:0]; end
      default: begin d2_a = a[11:0]; d2_b = b[6:0]; end
    endcase
    sw_sa[d] = sa; sw_sb[d] = sb; sw_iv[d] = 1'b1; sw_or[d] = 1'b1;
    w = 0;
    while (!sw_ir[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!sw_ir[d]) begin
      sw_iv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp);
    #1 sw_iv[d] = 1'b0;
    while (!sw_ov[d] && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
    case (d)
      0: res = {38'b0, d0_y};
      1: res = {53'b0, d1_y};
      default: res = {45'b0, d2_y};
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; din_a = '0; din_b = '0; sign_a = 1'b0; sign_b = 1'b0;
    sw_iv = '0; sw_or = '1; sw_sa = '0; sw_sb = '0;
    d0_a = '0; d0_b = '0; d1_a = '0; d1_b = '0; d2_a = '0; d2_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (dout !== 64'h0) $display("FAIL reset_dout: got %h expected 0", dout);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input bit sa, input bit sb, input logic [63:0] exp,
                               input bit toggle);
    logic [63:0] res, e;
    int lat;
    drive_op(a, b, sa, sb, exp, 1'b1, toggle, res, lat);
    e = pop_exp();
    n_checks++;
    if (res !== e) $display("FAIL %s_dout: got %h expected %h", name, res, e);
    else n_pass++;
    n_checks++;
    if (lat !== 5) $display("FAIL %s_latency: got %0d expected 5", name, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res, e;
    int lat, w;
    bit bp_bad;
    drive_op(32'd5, 32'd9, 1'b0, 1'b0, 64'd45, 1'b0, 1'b0, res, lat);
    e = pop_exp();
    n_checks++;
    if (res !== e) $display("FAIL bp_first_dout: got %h expected %h", res, e);
    else n_pass++;
    bp_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || dout !== 64'd45 || in_ready !== 1'b0) begin
        if (!bp_bad)
          $display("FAIL bp_hold: cycle %0d got v=%b d=%h r=%b expected v=1 d=2d r=0",
                   i, out_valid, dout, in_ready);
        bp_bad = 1'b1;
      end
    end
    n_checks++;
    if (!bp_bad) n_pass++;
    din_a = 32'd3; din_b = 32'hFFFF_FFFB; sign_a = 1'b1; sign_b = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    @(posedge clk);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    #1 in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_handshake: out_valid got %b expected 0", out_valid);
    else n_pass++;
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk);
      w++;
      #1;
    end
    e = pop_exp();
    n_checks++;
    if (dout !== e) $display("FAIL b2b_dout: got %h expected %h", dout, e);
    else n_pass++;
    n_checks++;
    if (w !== 5) $display("FAIL b2b_latency: got %0d expected 5", w);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w;
    @(negedge clk);
    din_a = 32'h1234_5678; din_b = 32'h9ABC_DEF0; sign_a = 1'b0; sign_b = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (dout !== 64'h0) $display("FAIL midrst_dout: got %h expected 0", dout);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    test_directed("after_reset", 32'd7, 32'd6, 1'b0, 1'b0, 64'd42, 1'b0);
  endtask

  task automatic test_random_default(input int n);
    logic [63:0] res, e, exp;
    logic [31:0] a, b;
    bit sa, sb;
    int lat;
    for (int i = 0; i < n; i++) begin
      a = pick32(); b = pick32();
      sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      exp = model({32'b0, a}, {32'b0, b}, sa, sb, 32, 32);
      drive_op(a, b, sa, sb, exp, 1'b1, (i % 5) == 0, res, lat);
      e = pop_exp();
      n_checks++;
      if (res !== e)
        $display("FAIL rand_dout: a=%h b=%h sa=%b sb=%b got %h expected %h", a, b, sa, sb, res, e);
      else n_pass++;
      n_checks++;
      if (lat !== 5) $display("FAIL rand_latency: got %0d expected 5", lat);
      else n_pass++;
    end
  endtask

  task automatic test_sweep(input int d, input int n);
    logic [63:0] res, e, exp, ma, mb;
    logic [31:0] a, b;
    bit sa, sb;
    int lat;
    ma = (64'd1 << sw_wa[d]) - 64'd1;
    mb = (64'd1 << sw_wb[d]) - 64'd1;
    for (int i = 0; i < n; i++) begin
      a = 32'($urandom) & ma[31:0];
      b = 32'($urandom) & mb[31:0];
      if (i < 4) begin
        a = (i[0]) ? ma[31:0] : (ma[31:0] ^ (ma[31:0] >> 1));
        b = (i[1]) ? mb[31:0] : (mb[31:0] ^ (mb[31:0] >> 1));
      end
      sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      exp = model({32'b0, a}, {32'b0, b}, sa, sb, sw_wa[d], sw_wb[d]);
      sw_op(d, a, b, sa, sb, exp, res, lat);
      e = pop_exp();
      n_checks++;
      if (res !== e)
        $display("FAIL sweep%0d_dout: a=%h b=%h sa=%b sb=%b got %h expected %h",
                 d, a, b, sa, sb, res, e);
      else n_pass++;
      n_checks++;
      if (lat !== sw_nd[d]) $display("FAIL sweep%0d_latency: got %0d expected %0d", d, lat, sw_nd[d]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed("ss", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
    test_directed("uu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
    test_directed("mixed", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_8000_0000,
                  1'b0);
    test_directed("mixed_toggle", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0,
                  64'h8000_0000_8000_0000, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_random_default(2500);
    for (int d = 0; d < 3; d++) test_sweep(d, 2500);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
